// File: rtl/b01_trace_pkg.sv
// Shared definitions for the b01 trace monitor.
// Contents:
//   state_e   - capture FSM states. The encoding is visible on state_o.
//   OUTP..STAMP_LSB - bit offsets of the fields inside one trace record.
//   rec_width - record width for a given cycle-stamp width.
package b01_trace_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StFrozen  = 2'd2
  } state_e;

  localparam int unsigned OUTP      = 0;
  localparam int unsigned OVF       = 1;
  localparam int unsigned L1        = 2;
  localparam int unsigned L2        = 3;
  localparam int unsigned STAMP_LSB = 4;

  function automatic int unsigned rec_width(input int unsigned cw);
    return cw + 4;
  endfunction

endpackage

// File: rtl/b01_trace_fifo.sv
// First-word-fall-through FIFO that buffers trace records.
// Ports:
//   clock, reset   - rising-edge clock; asynchronous, active-high reset (empties the FIFO)
//   push, wdata    - write request and record; ignored when full unless a pop happens too
//   pop            - consume the head; ignored when empty
//   rdata          - current head (meaningful only while !empty)
//   full, empty    - occupancy flags
//   count          - occupancy, 0..DEPTH
// The pointers are one bit wider than the address, so full and empty can be told apart.
module b01_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 20,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = pop & ~empty;
  // When full, a push on the same edge as a pop reuses the slot that is just being freed.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  // Storage is not reset: the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/b01_trace_monitor.sv
// Observation stage for the b01 serial adder/comparator.
// When obs is high during CAPTURE, the monitor samples the stimulus and response bits
// together with a free-running cycle stamp. Each sample goes into a FIFO that the harness
// drains over a valid/ready interface. The monitor also keeps saturating counts of
// overflow rising edges and of samples lost because the FIFO was full.
// Ports:
//   clock, reset            - rising-edge clock; asynchronous, active-high reset
//   enable, freeze          - arm capture / stop capture (sticky until reset)
//   obs                     - observation strobe
//   line1, line2            - b01 inputs
//   outp, overflw           - b01 outputs
//   rec_valid, rec_data     - FIFO head {stamp, line2, line1, overflw, outp}; data is 0 when not valid
//   rec_ready               - consumer accepts the head
//   fifo_full               - occupancy == DEPTH
//   ovf_count, drop_count   - saturating event counters
//   state_o                 - FSM state (IDLE=0, CAPTURE=1, FROZEN=2)
module b01_trace_monitor
  import b01_trace_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CW           = 16,
  parameter bit          STOP_ON_FULL = 1'b0,
  parameter int unsigned SAT_W        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     freeze,
  input  logic                     obs,
  input  logic                     line1,
  input  logic                     line2,
  input  logic                     outp,
  input  logic                     overflw,
  output logic                     rec_valid,
  output logic [rec_width(CW)-1:0] rec_data,
  input  logic                     rec_ready,
  output logic                     fifo_full,
  output logic [SAT_W-1:0]         ovf_count,
  output logic [SAT_W-1:0]         drop_count,
  output logic [1:0]               state_o
);

  localparam int unsigned RW = rec_width(CW);
  localparam int unsigned AW = $clog2(DEPTH);

  state_e           r_state;
  state_e           w_state_d;
  logic [CW-1:0]    r_stamp;
  logic             r_prev_ovf;
  logic [SAT_W-1:0] r_ovf_count;
  logic [SAT_W-1:0] r_drop_count;

  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [RW-1:0]    w_rec;
  logic [RW-1:0]    w_fifo_rdata;
  logic             w_pop;
  logic             w_sample;
  logic             w_push;
  logic             w_drop;
  logic             w_ovf_rise;

  // freeze wins over a coincident strobe.
  assign w_sample   = (r_state == StCapture) & obs & ~freeze;
  assign w_pop      = rec_valid & rec_ready;
  assign w_push     = w_sample & (~w_full | w_pop);
  assign w_drop     = w_sample & w_full & ~w_pop;
  assign w_ovf_rise = (r_state == StCapture) & overflw & ~r_prev_ovf;

  always_comb begin
    w_rec                     = '0;
    w_rec[OUTP]               = outp;
    w_rec[OVF]                = overflw;
    w_rec[L1]                 = line1;
    w_rec[L2]                 = line2;
    w_rec[STAMP_LSB +: CW]    = r_stamp;
  end

  b01_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .wdata (w_rec),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (freeze)      w_state_d = StFrozen;
        else if (enable) w_state_d = StCapture;
      end
      StCapture: begin
        if (freeze || (STOP_ON_FULL && w_drop)) w_state_d = StFrozen;
        else if (!enable)                       w_state_d = StIdle;
      end
      StFrozen: w_state_d = StFrozen;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_stamp      <= '0;
      r_prev_ovf   <= 1'b0;
      r_ovf_count  <= '0;
      r_drop_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_stamp    <= r_stamp + CW'(1);
      r_prev_ovf <= overflw;
      if (w_ovf_rise && (r_ovf_count != '1))  r_ovf_count  <= r_ovf_count + SAT_W'(1);
      if (w_drop && (r_drop_count != '1))     r_drop_count <= r_drop_count + SAT_W'(1);
    end
  end

  assign rec_valid  = ~w_empty;
  assign rec_data   = rec_valid ? w_fifo_rdata : '0;
  assign fifo_full  = (w_count == (AW + 1)'(DEPTH));
  assign ovf_count  = r_ovf_count;
  assign drop_count = r_drop_count;
  assign state_o    = r_state;

endmodule

// File: tb/tb_b01_trace_monitor.sv
module tb_b01_trace_monitor;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, freeze = 1'b0, obs = 1'b0;
  logic line1 = 1'b0, line2 = 1'b0, outp = 1'b0, overflw = 1'b0, rec_ready = 1'b0;

  // Instance A: counts drops (3-bit counters to reach saturation). Instance B: stops on full.
  logic       a_valid, a_full, b_valid, b_full;
  logic [7:0] a_data, b_data;
  logic [2:0] a_ovf, a_drop;
  logic [7:0] b_ovf, b_drop;
  logic [1:0] a_st, b_st;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  b01_trace_monitor #(.DEPTH(DEPTH), .CW(4), .STOP_ON_FULL(1'b0), .SAT_W(3)) dut_a (
    .clock(clk), .reset(reset), .enable(enable), .freeze(freeze), .obs(obs),
    .line1(line1), .line2(line2), .outp(outp), .overflw(overflw),
    .rec_valid(a_valid), .rec_data(a_data), .rec_ready(rec_ready), .fifo_full(a_full),
    .ovf_count(a_ovf), .drop_count(a_drop), .state_o(a_st)
  );

  b01_trace_monitor #(.DEPTH(DEPTH), .CW(4), .STOP_ON_FULL(1'b1), .SAT_W(8)) dut_b (
    .clock(clk), .reset(reset), .enable(enable), .freeze(freeze), .obs(obs),
    .line1(line1), .line2(line2), .outp(outp), .overflw(overflw),
    .rec_valid(b_valid), .rec_data(b_data), .rec_ready(rec_ready), .fifo_full(b_full),
    .ovf_count(b_ovf), .drop_count(b_drop), .state_o(b_st)
  );

  // ---------------- behavioural model (one slot per instance) ----------------
  int         m_st    [2] = '{0, 0};  // 0 idle, 1 capture, 2 frozen
  int         m_stamp [2] = '{0, 0};
  bit         m_prev  [2] = '{0, 0};
  int         m_ovf   [2] = '{0, 0};
  int         m_drop  [2] = '{0, 0};
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [7:0] qfront(input int k);
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  function automatic int satmax(input int k);
    return (k == 0) ? 7 : 255;
  endfunction

  function automatic bit stop_on_full(input int k);
    return k == 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_stamp[k] = 0; m_prev[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_step();
    int sz;
    bit pop, smp, drp;
    logic [3:0] stamp;
    logic [7:0] rec;
    for (int k = 0; k < 2; k++) begin
      sz    = qsize(k);
      pop   = (sz > 0) && rec_ready;
      smp   = (m_st[k] == 1) && obs && !freeze;
      drp   = 1'b0;
      stamp = 4'(m_stamp[k]);
      rec   = {stamp, line2, line1, overflw, outp};
      if (pop) begin
        if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
      if (smp) begin
        if (sz < DEPTH || pop) begin
          if (k == 0) qa.push_back(rec); else qb.push_back(rec);
        end else begin
          drp = 1'b1;
          if (m_drop[k] < satmax(k)) m_drop[k]++;
        end
      end
      if (m_st[k] == 1 && overflw && !m_prev[k] && m_ovf[k] < satmax(k)) m_ovf[k]++;
      m_prev[k]  = overflw;
      m_stamp[k] = (m_stamp[k] + 1) % 16;
      case (m_st[k])
        0: m_st[k] = freeze ? 2 : (enable ? 1 : 0);
        1: m_st[k] = (freeze || (stop_on_full(k) && drp)) ? 2 : (enable ? 1 : 0);
        default: m_st[k] = 2;
      endcase
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic v, input logic [7:0] d, input logic f,
                          input logic [7:0] ov, input logic [7:0] dr, input logic [1:0] st);
    int sz;
    logic [7:0] ed;
    sz = qsize(k);
    ed = (sz > 0) ? qfront(k) : 8'h00;
    chk("rec_valid", k, 32'(v), 32'(sz > 0));
    chk("rec_data", k, 32'(d), 32'(ed));
    chk("fifo_full", k, 32'(f), 32'(sz == DEPTH));
    chk("ovf_count", k, 32'(ov), 32'(m_ovf[k]));
    chk("drop_count", k, 32'(dr), 32'(m_drop[k]));
    chk("state_o", k, 32'(st), 32'(m_st[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_inst(0, a_valid, a_data, a_full, {5'b0, a_ovf}, {5'b0, a_drop}, a_st);
      cmp_inst(1, b_valid, b_data, b_full, b_ovf, b_drop, b_st);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic l1, input logic l2, input logic o, input logic ov);
    line1 = l1; line2 = l2; outp = o; overflw = ov;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int rdy_pct = 50;

  initial begin
    do_reset();
    cmp_on = 1'b1;

    // Basic capture: the enabling edge (stamp 0) is not sampled.
    enable = 1'b1; rec_ready = 1'b1;
    tick();
    chk("lit_state_capture", 0, 32'(a_st), 32'd1);
    chk("lit_empty_after_enable", 0, 32'(a_valid), 32'd0);
    obs = 1'b1;
    set_in(1, 0, 1, 0); tick();
    chk("lit_rec1", 0, 32'(a_data), 32'h15);
    set_in(0, 1, 1, 0); tick();
    chk("lit_rec2", 0, 32'(a_data), 32'h29);
    set_in(1, 1, 0, 1); tick();
    chk("lit_rec3", 0, 32'(a_data), 32'h3E);
    chk("lit_ovf1", 0, 32'(a_ovf), 32'd1);
    chk("lit_drop0", 0, 32'(a_drop), 32'd0);
    obs = 1'b0; set_in(0, 0, 0, 0);

    // Overfill with no consumer; B stops on its first drop.
    do_reset();
    enable = 1'b1; rec_ready = 1'b0; obs = 1'b0;
    tick();
    obs = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      set_in(1'(i), 1'(i >> 1), 1'(i >> 2), 1'b0);
      tick();
      if (i == 4) chk("lit_full_after4", 0, 32'(a_full), 32'd1);
      if (i == 5) begin
        chk("lit_b_frozen", 1, 32'(b_st), 32'd2);
        chk("lit_b_drop1", 1, 32'(b_drop), 32'd1);
      end
    end
    chk("lit_a_drop2", 0, 32'(a_drop), 32'd2);
    chk("lit_a_head_stamp1", 0, 32'(a_data[7:4]), 32'd1);

    // Full FIFO, push and pop on the same edge.
    rec_ready = 1'b1; obs = 1'b1;
    tick();
    chk("lit_full_kept", 0, 32'(a_full), 32'd1);
    chk("lit_drop_kept", 0, 32'(a_drop), 32'd2);
    chk("lit_head_stamp2", 0, 32'(a_data[7:4]), 32'd2);

    // FROZEN is terminal; strobes and toggles have no effect.
    rec_ready = 1'b0;
    enable = 1'b0; freeze = 1'b0; tick();
    enable = 1'b1; freeze = 1'b1; tick();
    freeze = 1'b0; obs = 1'b1; tick(); tick();
    chk("lit_b_still_frozen", 1, 32'(b_st), 32'd2);
    chk("lit_b_drop_still1", 1, 32'(b_drop), 32'd1);
    obs = 1'b0; rec_ready = 1'b1;
    repeat (4) tick();
    chk("lit_a_drained", 0, 32'(a_valid), 32'd0);

    // Stamp wrap with CW=4.
    do_reset();
    enable = 1'b1; rec_ready = 1'b0; obs = 1'b0;
    tick();
    for (int e = 1; e <= 17; e++) begin
      obs = (e >= 15);
      tick();
    end
    obs = 1'b0;
    chk("lit_wrap_15", 0, 32'(a_data[7:4]), 32'd15);
    rec_ready = 1'b1; tick();
    chk("lit_wrap_0", 0, 32'(a_data[7:4]), 32'd0);
    tick();
    chk("lit_wrap_1", 0, 32'(a_data[7:4]), 32'd1);
    tick();

    // Asynchronous reset between edges.
    do_reset();
    enable = 1'b1; rec_ready = 1'b0; obs = 1'b0;
    tick();
    obs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'(i), 1'(~i), 1'(i >> 1), 1'(i == 0));
      tick();
    end
    obs = 1'b0;
    chk("lit_pre_rst_valid", 0, 32'(a_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("lit_arst_valid_a", 0, 32'(a_valid), 32'd0);
    chk("lit_arst_state_a", 0, 32'(a_st), 32'd0);
    chk("lit_arst_ovf_a", 0, 32'(a_ovf), 32'd0);
    chk("lit_arst_drop_a", 0, 32'(a_drop), 32'd0);
    chk("lit_arst_valid_b", 1, 32'(b_valid), 32'd0);
    chk("lit_arst_state_b", 1, 32'(b_st), 32'd0);
    tick();
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 100) == 0) rdy_pct = int'($urandom_range(5, 95));
      if ($urandom_range(0, 119) == 0) do_reset();
      enable    = ($urandom_range(0, 9) != 0);
      freeze    = ($urandom_range(0, 199) == 0);
      obs       = 1'($urandom_range(0, 1));
      line1     = 1'($urandom_range(0, 1));
      line2     = 1'($urandom_range(0, 1));
      outp      = 1'($urandom_range(0, 1));
      overflw   = 1'($urandom_range(0, 1));
      rec_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      tick();
    end

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
